sram_client_arbiter: RTL

- Shares one spi_sram_encoder between two Hack-side memory clients: client 0 is the CPU data port, client 1 is the display/video fetch port.
- Accepts level requests from each client and arbitrates between them. Drives the encoder's request/address/write_enable/data_out and returns encoder data_in and a one-cycle ack to the winning client.
- Sits between the CPU/video logic and the encoder. The encoder and its SRAM pins are unchanged.

---
 rtl/sram_client_arbiter.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_client_arbiter.sv
// -----------------------------------------------------------------------------
// sram_client_arbiter
//
// Lets two Hack-side memory clients share one spi_sram_encoder.
//   client 0 : CPU data port
//   client 1 : display/video fetch port
// Each client holds a level request, plus its address, write enable and write
// data, until it gets a one-cycle ack. The arbiter picks a winner while idle,
// runs a single encoder transaction for that winner and then returns the ack
// (and, for reads, the read data) to it.
//
// Optional build macro: SRAM_ARB_C1_PRIORITY_EN
//   undefined : round-robin on contention (the client that is not `grant` wins)
//   defined   : client 1 wins every simultaneous request
//
// Ports
//   clk, reset          system clock, asynchronous active-low reset
//   cN_req              client N request (level, held until cN_ack)
//   cN_addr             client N address
//   cN_we               client N write enable (1 = write)
//   cN_wdata            client N write data
//   cN_ack              one-cycle completion pulse to client N
//   cN_rdata            client N read data, valid from cN_ack onward
//   enc_request         request to encoder
//   enc_address         address to encoder
//   enc_write_enable    write enable to encoder
//   enc_wdata           write data to encoder (encoder data_out)
//   enc_rdata           read data from encoder (encoder data_in)
//   enc_busy            encoder busy
//   enc_initialized     encoder has finished its SRAM init sequence
//   grant               client owning the current / last transaction
//   active              high while a transaction is in flight
// -----------------------------------------------------------------------------
module sram_client_arbiter #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     c0_req,
  input  logic [ADDRESS_WIDTH-1:0] c0_addr,
  input  logic                     c0_we,
  input  logic [WORD_WIDTH-1:0]    c0_wdata,
  output logic                     c0_ack,
  output logic [WORD_WIDTH-1:0]    c0_rdata,

  input  logic                     c1_req,
  input  logic [ADDRESS_WIDTH-1:0] c1_addr,
  input  logic                     c1_we,
  input  logic [WORD_WIDTH-1:0]    c1_wdata,
  output logic                     c1_ack,
  output logic [WORD_WIDTH-1:0]    c1_rdata,

  output logic                     enc_request,
  output logic [ADDRESS_WIDTH-1:0] enc_address,
  output logic                     enc_write_enable,
  output logic [WORD_WIDTH-1:0]    enc_wdata,
  input  logic [WORD_WIDTH-1:0]    enc_rdata,
  input  logic                     enc_busy,
  input  logic                     enc_initialized,

  output logic                     grant,
  output logic                     active
);

  // state     | meaning
  // ----------+----------------------------------------------------------
  // IDLE      | no transaction; arbitrate when the encoder is ready
  // ISSUE     | enc_request held high until the encoder reports busy
  // WAIT_DONE | encoder working; finish on the first enc_busy=0 sample
  // RESP      | ack pulse to the granted client, then back to IDLE
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  state_t                   state, state_d;
  logic                     enc_request_d;
  logic [ADDRESS_WIDTH-1:0] enc_address_d;
  logic                     enc_write_enable_d;
  logic [WORD_WIDTH-1:0]    enc_wdata_d;
  logic                     c0_ack_d, c1_ack_d;
  logic [WORD_WIDTH-1:0]    c0_rdata_d, c1_rdata_d;
  logic                     grant_d;
  logic                     active_d;

  logic                     launch;
  logic                     winner;

  // A new transaction may only start when the encoder will accept it.
  assign launch = enc_initialized && !enc_busy && (c0_req || c1_req);

`ifdef SRAM_ARB_C1_PRIORITY_EN
  // Video fetch owns the bus whenever it asks; the CPU only gets leftovers.
  assign winner = c1_req;
`else
  // On a tie the client that did not own the last transaction goes next.
  // grant resets to 1 so the CPU wins the first tie.
  assign winner = (c0_req && c1_req) ? ~grant : c1_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      enc_request      <= 1'b0;
      enc_address      <= '0;
      enc_write_enable <= 1'b0;
      enc_wdata        <= '0;
      c0_ack           <= 1'b0;
      c1_ack           <= 1'b0;
      c0_rdata         <= '0;
      c1_rdata         <= '0;
      grant            <= 1'b1;
      active           <= 1'b0;
    end else begin
      state            <= state_d;
      enc_request      <= enc_request_d;
      enc_address      <= enc_address_d;
      enc_write_enable <= enc_write_enable_d;
      enc_wdata        <= enc_wdata_d;
      c0_ack           <= c0_ack_d;
      c1_ack           <= c1_ack_d;
      c0_rdata         <= c0_rdata_d;
      c1_rdata         <= c1_rdata_d;
      grant            <= grant_d;
      active           <= active_d;
    end
  end

  always_comb begin
    state_d            = state;
    enc_request_d      = enc_request;
    enc_address_d      = enc_address;
    enc_write_enable_d = enc_write_enable;
    enc_wdata_d        = enc_wdata;
    c0_ack_d           = 1'b0;
    c1_ack_d           = 1'b0;
    c0_rdata_d         = c0_rdata;
    c1_rdata_d         = c1_rdata;
    grant_d            = grant;
    active_d           = active;

    case (state)
      IDLE: begin
        if (launch) begin
          grant_d       = winner;
          active_d      = 1'b1;
          enc_request_d = 1'b1;
          if (winner) begin
            enc_address_d      = c1_addr;
            enc_write_enable_d = c1_we;
            enc_wdata_d        = c1_wdata;
          end else begin
            enc_address_d      = c0_addr;
            enc_write_enable_d = c0_we;
            enc_wdata_d        = c0_wdata;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (enc_busy) begin
          enc_request_d = 1'b0;
          state_d       = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        // enc_rdata is only meaningful in the first cycle busy is low again.
        // enc_initialized is deliberately ignored here: once started, a
        // transaction is always allowed to drain.
        if (!enc_busy) begin
          if (grant) begin
            c1_ack_d = 1'b1;
            if (!enc_write_enable) c1_rdata_d = enc_rdata;
          end else begin
            c0_ack_d = 1'b1;
            if (!enc_write_enable) c0_rdata_d = enc_rdata;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        // Clients update req on the ack edge; skipping arbitration for this
        // one cycle keeps a stale req from being serviced twice.
        active_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
